// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the LEGv8 5-stage pipeline.
// Owns the PC, presents it to the combinational instruction ROM and captures the
// returned word into the IF/ID register. Handles stall, branch redirect and a
// sticky fetch fault (misaligned PC or PC+3 >= IMEM_BYTES) that parks the stage
// in HALT until reset.
//
// Ports:
//   clk, reset_n              clock; synchronous active-low reset
//   imem_addr  / imem_instr   ROM byte address (= PC) / word returned same cycle
//   stall                     hold PC and IF/ID
//   br_taken   / br_target    redirect request and its byte address
//   ifid_pc / ifid_instr / ifid_valid   IF/ID register contents
//   fetch_fault               sticky fault flag
//   perf_fetched / perf_bubbles         IF/ID load counters
//
// Optional feature: define FETCH_PERF_CNT_EN to build the two perf counters;
// otherwise both ports read 32'h0 and no counter flops exist.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_WORD   = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic                 ifid_valid_q, ifid_valid_d;
  logic                 fault_q, fault_d;
  logic                 load_valid_c;
  logic                 load_bubble_c;
  logic                 pc_bad_c;

  // Current PC is misaligned or the 4-byte word would run past the ROM.
  assign pc_bad_c = (pc_q[1:0] != 2'b00) ||
                    ((pc_q + PC_W'(3)) >= PC_W'(IMEM_BYTES));

  // Next-state: redirect > fault > stall > sequential fetch; HALT holds everything.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_valid_d  = ifid_valid_q;
    fault_d       = fault_q;
    load_valid_c  = 1'b0;
    load_bubble_c = 1'b0;

    if (state_q == S_RUN) begin
      if (br_taken) begin
        pc_d          = br_target;
        ifid_instr_d  = NOP_WORD;
        ifid_valid_d  = 1'b0;
        load_bubble_c = 1'b1;
      end else if (pc_bad_c) begin
        state_d       = S_HALT;
        fault_d       = 1'b1;
        ifid_instr_d  = NOP_WORD;
        ifid_valid_d  = 1'b0;
        load_bubble_c = 1'b1;
      end else if (!stall) begin
        // Only path that samples imem_instr, so ROM X elsewhere never reaches IF/ID.
        pc_d         = pc_q + PC_W'(4);
        ifid_pc_d    = pc_q;
        ifid_instr_d = imem_instr;
        ifid_valid_d = 1'b1;
        load_valid_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      fault_q      <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetched_q, fetched_d;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;

  // Counters wrap naturally; stall and HALT edges load nothing and count nothing.
  always_comb begin
    fetched_d = fetched_q;
    bubbles_d = bubbles_q;
    if (load_valid_c)  fetched_d = fetched_q + CNT_W'(1);
    if (load_bubble_c) bubbles_d = bubbles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = CNT_W'(0);
  assign perf_bubbles = CNT_W'(0);
`endif

  assign imem_addr   = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A reference model predicts
// the IF/ID contents for every edge; predictions are queued when inputs are
// driven and popped/compared after the edge. Directed checks follow the
// scenarios in the test plan; a short random phase follows.
module tb_fetch_stage;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam logic [31:0] NOP_WORD   = 32'hD503201F;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(
    .RESET_PC  (64'h0),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_WORD  (NOP_WORD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .ifid_pc     (ifid_pc),
    .ifid_instr  (ifid_instr),
    .ifid_valid  (ifid_valid),
    .fetch_fault (fetch_fault),
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word index tagged so each word is distinct and never NOP_WORD.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    return {8'hA1, 14'h0, a[11:2]};
  endfunction

  function automatic logic in_rom(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a < 64'(IMEM_BYTES - 3));
  endfunction

  assign imem_instr = in_rom(imem_addr) ? rom_word(imem_addr) : 32'hxxxxxxxx;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [63:0] m_pc;
  logic        m_halt;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_ifvalid;
  logic        m_fault;
  logic [31:0] m_fet;
  logic [31:0] m_bub;
  logic        started = 1'b0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        fault;
    logic [31:0] fet;
    logic [31:0] bub;
    logic [63:0] next_pc;
  } exp_t;

  exp_t sb[$];

  task automatic model_edge(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    logic bad;
    bad = (m_pc[1:0] != 2'b00) || ((m_pc + 64'd3) >= 64'(IMEM_BYTES));
    if (!rst) begin
      m_pc = 64'h0; m_halt = 1'b0; m_ifpc = 64'h0; m_ifinstr = NOP_WORD;
      m_ifvalid = 1'b0; m_fault = 1'b0; m_fet = 32'h0; m_bub = 32'h0;
    end else if (!m_halt) begin
      if (br) begin
        m_pc = tgt; m_ifinstr = NOP_WORD; m_ifvalid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_bub++;
`endif
      end else if (bad) begin
        m_halt = 1'b1; m_fault = 1'b1; m_ifinstr = NOP_WORD; m_ifvalid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        m_bub++;
`endif
      end else if (!st) begin
        m_ifpc = m_pc; m_ifinstr = rom_word(m_pc); m_ifvalid = 1'b1;
        m_pc = m_pc + 64'd4;
`ifdef FETCH_PERF_CNT_EN
        m_fet++;
`endif
      end
    end
  endtask

  // One clock: drive inputs, predict, let the edge happen, compare at +1.
  task automatic step(input logic rst, input logic st, input logic br, input logic [63:0] tgt);
    exp_t e;
    reset_n = rst; stall = st; br_taken = br; br_target = tgt;
    if (started) check_eq("imem_addr", imem_addr, m_pc);
    model_edge(rst, st, br, tgt);
    started = 1'b1;
    e.pc = m_ifpc; e.instr = m_ifinstr; e.valid = m_ifvalid; e.fault = m_fault;
    e.fet = m_fet; e.bub = m_bub; e.next_pc = m_pc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("ifid_valid", 64'(ifid_valid), 64'(e.valid));
    check_eq("ifid_instr", 64'(ifid_instr), 64'(e.instr));
    if (e.valid) check_eq("ifid_pc", ifid_pc, e.pc);
    check_eq("fetch_fault", 64'(fetch_fault), 64'(e.fault));
    check_eq("perf_fetched", 64'(perf_fetched), 64'(e.fet));
    check_eq("perf_bubbles", 64'(perf_bubbles), 64'(e.bub));
    check_eq("pc_after", imem_addr, e.next_pc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check_eq("rst_pc", imem_addr, 64'h0);
    check_eq("rst_valid", 64'(ifid_valid), 64'h0);
    check_eq("rst_instr", 64'(ifid_instr), 64'(NOP_WORD));
    check_eq("rst_ifid_pc", ifid_pc, 64'h0);
    check_eq("rst_fault", 64'(fetch_fault), 64'h0);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 64'h0;
    do_reset();

    // Free run: 0,4 fetched -> PC=8, ifid_pc=4
    run(2);
    check_eq("seq_ifid_pc", ifid_pc, 64'd4);
    check_eq("seq_instr", 64'(ifid_instr), 64'(32'hA100_0001));
    // Stall two cycles at PC=8
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("stall_pc", imem_addr, 64'd8);
    check_eq("stall_ifid_pc", ifid_pc, 64'd4);
    run(2);
    check_eq("resume_ifid_pc", ifid_pc, 64'd12);
    check_eq("resume_pc", imem_addr, 64'd16);

    // Branch wins over simultaneous stall
    step(1'b1, 1'b1, 1'b1, 64'd64);
    check_eq("br_pc", imem_addr, 64'd64);
    check_eq("br_valid", 64'(ifid_valid), 64'h0);
    check_eq("br_instr", 64'(ifid_instr), 64'(NOP_WORD));
    run(1);
    check_eq("br_tgt_ifid_pc", ifid_pc, 64'd64);
    check_eq("br_tgt_valid", 64'(ifid_valid), 64'h1);

    // Misaligned target: one cycle at 66, then HALT; later redirect ignored
    step(1'b1, 1'b0, 1'b1, 64'd66);
    check_eq("mis_pc", imem_addr, 64'd66);
    check_eq("mis_fault_early", 64'(fetch_fault), 64'h0);
    run(1);
    check_eq("mis_fault", 64'(fetch_fault), 64'h1);
    step(1'b1, 1'b0, 1'b1, 64'd0);
    step(1'b1, 1'b1, 1'b0, 64'd0);
    check_eq("halt_pc", imem_addr, 64'd66);
    check_eq("halt_fault", 64'(fetch_fault), 64'h1);
    do_reset();

    // Run off the end of ROM
    step(1'b1, 1'b0, 1'b1, 64'd1012);
    run(3);
    check_eq("end_ifid_pc", ifid_pc, 64'd1020);
    check_eq("end_pc", imem_addr, 64'd1024);
    run(1);
    check_eq("end_fault", 64'(fetch_fault), 64'h1);
    check_eq("end_valid", 64'(ifid_valid), 64'h0);
    check_eq("end_last_pc", ifid_pc, 64'd1020);

    // Top-of-address-space target trips the bounds check
    do_reset();
    step(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    run(1);
    check_eq("wrap_fault", 64'(fetch_fault), 64'h1);

    // Perf: 10 fetches, 2 stalls, 1 taken branch
    do_reset();
    run(5);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    run(5);
    step(1'b1, 1'b0, 1'b1, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fet_total", 64'(perf_fetched), 64'd10);
    check_eq("perf_bub_total", 64'(perf_bubbles), 64'd1);
`else
    check_eq("perf_fet_off", 64'(perf_fetched), 64'd0);
    check_eq("perf_bub_off", 64'(perf_bubbles), 64'd0);
`endif

    // Random mix; reset occasionally to leave HALT
    for (int i = 0; i < 300; i++) begin
      logic [63:0] tgt;
      tgt = 64'($urandom_range(0, 260)) << 2;
      if ($urandom_range(0, 9) == 0) tgt = tgt + 64'($urandom_range(1, 3));
      if (m_halt && $urandom_range(0, 3) == 0)
        step(1'b0, 1'b0, 1'b0, 64'h0);
      else
        step(1'b1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
